mnist_frame_sequencer: RTL and testbench

Sequencer that drives the LGN MNIST inference core on the iCEBreaker build. It streams one stored frame byte-by-byte from a synchronous pattern ROM into the core's `ui_in` and waits a fixed result latency. It then captures the core's class index and output value for the seven-segment and LED drivers, and steps to the next frame on a debounced button press or a dwell timer.

---
 rtl/mnist_frame_sequencer.sv | 109 ++++++++++
 tb/tb_mnist_frame_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mnist_frame_sequencer.sv
// mnist_frame_sequencer: streams a ROM frame into the MNIST core, captures its result,
// then dwells until a debounced button press or the dwell timer selects the next frame.
module mnist_frame_sequencer #(
    parameter int NUM_FRAMES      = 4,
    parameter int BYTES_PER_FRAME = 32,
    parameter int RESULT_LATENCY  = 16,
    parameter int DWELL_CYCLES    = 12_000_000,
    parameter int DEBOUNCE_CYCLES = 120_000
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          btn_next,
    input  logic                                          auto_en,
    output logic [$clog2(NUM_FRAMES*BYTES_PER_FRAME)-1:0] rom_addr,
    input  logic [7:0]                                    rom_data,
    output logic [7:0]                                    core_ui_in,
    input  logic [3:0]                                    core_index,
    input  logic [7:0]                                    core_value,
    output logic [3:0]                                    result_index,
    output logic [7:0]                                    result_value,
    output logic                                          result_valid,
    output logic [$clog2(NUM_FRAMES)-1:0]                 frame_sel,
    output logic                                          busy
);
    localparam int FW  = $clog2(NUM_FRAMES);
    localparam int BW  = $clog2(BYTES_PER_FRAME);
    localparam int CW  = $clog2((BYTES_PER_FRAME > RESULT_LATENCY ? BYTES_PER_FRAME : RESULT_LATENCY) + 1);
    localparam int DW  = $clog2(DWELL_CYCLES + 1);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {S_FETCH, S_STREAM, S_WAIT, S_CAPTURE, S_DWELL} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [DW-1:0]  dwell_cnt;
    logic [DBW-1:0] db_cnt;
    logic [1:0]     sync;
    logic           db_level, db_event, pending, timer_hit, advance;
    logic [BW-1:0]  next_off;
    logic [FW-1:0]  frame_nx;

    always_ff @(posedge clk)
        state <= !rst_n ? S_FETCH : state_nx;

    always_comb begin
        timer_hit = auto_en && dwell_cnt == DW'(DWELL_CYCLES - 1);
        advance   = state == S_DWELL && (pending || db_event || timer_hit);
        busy      = state != S_DWELL;
        frame_nx  = frame_sel + 1'b1;
        // address runs one byte ahead of the ROM output and parks on the last byte
        next_off  = (state == S_FETCH) ? BW'(1) :
                    (cnt >= CW'(BYTES_PER_FRAME - 2)) ? BW'(BYTES_PER_FRAME - 1) : BW'(cnt + CW'(2));
        state_nx  = state;
        case (state)
            S_FETCH:   state_nx = S_STREAM;
            S_STREAM:  if (cnt == CW'(BYTES_PER_FRAME - 1)) state_nx = S_WAIT;
            S_WAIT:    if (cnt == CW'(RESULT_LATENCY - 1)) state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_DWELL;
            default:   if (advance) state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync         <= '0;
            db_level     <= 1'b0;
            db_cnt       <= '0;
            db_event     <= 1'b0;
            pending      <= 1'b0;
            cnt          <= '0;
            dwell_cnt    <= '0;
            rom_addr     <= '0;
            core_ui_in   <= '0;
            result_index <= '0;
            result_value <= '0;
            result_valid <= 1'b0;
            frame_sel    <= '0;
        end else begin
            sync     <= {sync[0], btn_next};
            db_event <= 1'b0;
            if (sync[1] == db_level)
                db_cnt <= '0;
            else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= sync[1];
                db_cnt   <= '0;
                db_event <= sync[1];
            end else
                db_cnt <= db_cnt + 1'b1;
            cnt        <= (state_nx != state || state == S_DWELL) ? '0 : cnt + 1'b1;
            dwell_cnt  <= (state == S_DWELL && auto_en) ? dwell_cnt + 1'b1 : '0;
            core_ui_in <= state == S_STREAM ? rom_data : 8'h00;
            if (state == S_FETCH || state == S_STREAM)
                rom_addr <= {frame_sel, next_off};
            if (state == S_CAPTURE) begin
                result_index <= core_index;
                result_value <= core_value;
                result_valid <= 1'b1;
            end
            if (busy && db_event)
                pending <= 1'b1;
            if (advance) begin
                frame_sel    <= frame_nx;
                rom_addr     <= {frame_nx, BW'(0)};
                result_valid <= 1'b0;
                pending      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mnist_frame_sequencer.sv
// tb_mnist_frame_sequencer: directed plan plus random button/auto/reset traffic,
// checked every cycle against a frame-timeline model of the sequencer.
module tb_mnist_frame_sequencer;
    localparam int NF  = 4;
    localparam int B   = 32;
    localparam int L   = 16;
    localparam int DWC = 100;
    localparam int DB  = 4;
    localparam int CAP = B + L + 1;

    logic       clk = 0, rst_n = 0, btn_next = 0, auto_en = 0;
    logic [6:0] rom_addr;
    logic [7:0] rom_data, core_ui_in, core_value, result_value;
    logic [3:0] core_index, result_index;
    logic       result_valid, busy;
    logic [1:0] frame_sel;
    logic [7:0] rom [NF*B];
    int         checks = 0, failures = 0, cyc = 0;

    bit          m_on = 0;
    int          m_c, m_frame, m_t;
    logic        m_pend, m_valid, m_lvl, m_evt, m_b1, m_b2;
    logic [3:0]  m_idx, s_idx;
    logic [7:0]  m_val, s_val;
    logic [15:0] m_hist;

    mnist_frame_sequencer #(
        .NUM_FRAMES(NF), .BYTES_PER_FRAME(B), .RESULT_LATENCY(L),
        .DWELL_CYCLES(DWC), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .auto_en(auto_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .core_ui_in(core_ui_in),
        .core_index(core_index), .core_value(core_value),
        .result_index(result_index), .result_value(result_value),
        .result_valid(result_valid), .frame_sel(frame_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) cyc <= !rst_n ? 0 : cyc + 1;
    always @(posedge clk) if (rst_n && cyc == CAP) begin
        s_idx <= core_index;
        s_val <= core_value;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Model: a frame is a timeline of cycle offsets from its FETCH; the button is
    // a two-cycle delayed sample whose level flips after DB differing samples.
    always @(posedge clk) begin : model
        logic [15:0] h;
        logic        flip;
        if (!rst_n) begin
            m_on <= 1; m_c <= 0; m_frame <= 0; m_t <= 0; m_pend <= 0; m_valid <= 0;
            m_idx <= 0; m_val <= 0; m_lvl <= 0; m_evt <= 0; m_b1 <= 0; m_b2 <= 0; m_hist <= 0;
        end else if (m_on) begin
            h = {m_hist[14:0], m_b2};
            flip = 1;
            for (int i = 0; i < DB; i++) if (h[i] == m_lvl) flip = 0;
            m_hist <= h;
            if (flip) m_lvl <= ~m_lvl;
            m_evt <= flip && !m_lvl;
            m_b2 <= m_b1;
            m_b1 <= btn_next;
            if (m_c == CAP) begin
                m_idx <= core_index;
                m_val <= core_value;
                m_valid <= 1;
            end
            if (m_c > CAP) begin
                if (m_pend || m_evt || (auto_en && m_t == DWC - 1)) begin
                    m_frame <= (m_frame + 1) % NF;
                    m_c <= 0;
                    m_pend <= 0;
                    m_valid <= 0;
                end else
                    m_c <= m_c + 1;
                m_t <= auto_en ? m_t + 1 : 0;
            end else begin
                if (m_evt) m_pend <= 1;
                m_c <= m_c + 1;
                m_t <= 0;
            end
        end
    end

    initial forever begin : cmp
        @(negedge clk);
        if (m_on) begin
            automatic int ea = m_frame * B + (m_c < B - 1 ? m_c : B - 1);
            automatic int eu = (m_c >= 2 && m_c <= B + 1) ? int'(rom[m_frame * B + m_c - 2]) : 0;
            chk("m_rom_addr", rom_addr, ea);
            chk("m_core_ui_in", core_ui_in, eu);
            chk("m_busy", busy, m_c <= CAP);
            chk("m_frame_sel", frame_sel, m_frame);
            chk("m_result_valid", result_valid, m_valid);
            chk("m_result_index", result_index, m_idx);
            chk("m_result_value", result_value, m_val);
        end
    end

    initial forever begin
        @(negedge clk);
        core_index = 4'($urandom);
        core_value = 8'($urandom);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int n = 0; n < NF * B; n++) rom[n] = 8'(n);
        core_index = 0;
        core_value = 0;
        rst_n = 0;
        auto_en = 1;
        repeat (3) @(negedge clk);
        rst_n = 1;
        chk("rst_frame", frame_sel, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_valid", result_valid, 0);
        at(2);    chk("byte0", core_ui_in, 8'h00);
        at(3);    chk("byte1", core_ui_in, 8'h01);
        at(33);   chk("byte31", core_ui_in, 8'h1F);
        at(34);   chk("after_bytes", core_ui_in, 8'h00);
        at(49);   chk("valid_49", result_valid, 0); chk("busy_49", busy, 1);
        at(50);   chk("valid_50", result_valid, 1); chk("busy_50", busy, 0);
                  chk("idx_50", result_index, s_idx); chk("val_50", result_value, s_val);
        at(149);  chk("auto_f0_hold", frame_sel, 0);
        at(150);  chk("auto_f1", frame_sel, 1); chk("auto_f1_addr", rom_addr, 7'h20);
        at(450);  chk("auto_f3", frame_sel, 3); chk("auto_f3_addr", rom_addr, 7'h60);
        at(452);  chk("f3_first", core_ui_in, 8'h60);
        at(483);  chk("f3_last", core_ui_in, 8'h7F);
        at(599);  chk("auto_f3_hold", frame_sel, 3);
        at(600);  chk("auto_wrap", frame_sel, 0);
        at(610);  auto_en = 0;
        at(700);  btn_next = 1;
        at(706);  chk("press_hold", frame_sel, 0);
        at(707);  chk("press_adv", frame_sel, 1);
        at(710);  btn_next = 0;
        at(800);  btn_next = 1;
        at(802);  btn_next = 0;
        at(850);  chk("glitch_none", frame_sel, 1); chk("glitch_valid", result_valid, 1);
        at(900);  btn_next = 1;
        at(908);  btn_next = 0;
        for (int p = 0; p < 3; p++) begin
            at(914 + 12 * p); btn_next = 1;
            at(920 + 12 * p); btn_next = 0;
        end
        at(956);  chk("pend_busy", busy, 1); chk("pend_f2", frame_sel, 2);
        at(957);  chk("pend_dwell", busy, 0); chk("pend_hold", frame_sel, 2);
        at(958);  chk("pend_adv", frame_sel, 3);
        at(1100); chk("pend_once", frame_sel, 3); chk("pend_idle", busy, 0);
        auto_en = 1;
        at(1193); btn_next = 1;
        at(1199); chk("coin_hold", frame_sel, 3);
        at(1200); chk("coin_adv", frame_sel, 0);
        at(1203); btn_next = 0;
        at(1349); chk("coin_once", frame_sel, 0);
        at(1350); chk("coin_timer", frame_sel, 1);
        at(1511); chk("rs_frame", frame_sel, 2); chk("rs_addr", rom_addr, 7'h4B);
                  chk("rs_byte9", core_ui_in, 8'h49);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("rs_frame0", frame_sel, 0);
        chk("rs_addr0", rom_addr, 0);
        chk("rs_ui0", core_ui_in, 0);
        chk("rs_valid0", result_valid, 0);
        chk("rs_idx0", result_index, 0);
        chk("rs_val0", result_value, 0);
        at(3);    chk("rs_byte1", core_ui_in, 8'h01);
        at(49);   chk("rs_valid_49", result_valid, 0);
        at(50);   chk("rs_valid_50", result_valid, 1); chk("rs_idx_50", result_index, s_idx);
        begin
            automatic int bl = 0;
            for (int i = 0; i < 4000; i++) begin
                @(negedge clk);
                if (bl == 0) begin
                    btn_next = 1'($urandom_range(0, 1));
                    bl = $urandom_range(1, 12);
                end
                bl--;
                if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
                rst_n = $urandom_range(0, 1499) != 0;
            end
        end
        rst_n = 1;
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
